// File: rtl/core_id_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : core_id_reg_file_mp
// Description : Multi-read-port register file with a per-entry scoreboard.
//               After reset an INIT sequence zeroes every entry, one per cycle.
//               Then the RUN state serves one write port, NUM_RD read ports
//               (one-cycle latency) and issue/write-back busy tracking.
//               The optional macro CORE_REG_FILE_BYPASS_EN forwards a
//               same-cycle write to a read of the same address.
// Revision    : 1.0 - initial release
// ============================================================================
module core_id_reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_en,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic                       init_done
);

    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};
    localparam bit              c_ZERO = (ZERO_REG != 0);

`ifdef CORE_REG_FILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_next;

    logic                w_run;
    logic                w_wr_ok;
    logic                w_set_ok;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_sb;
    logic [DEPTH-1:0]    w_sb_next;

    // State and clear-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: walk the counter through every entry, then run
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    assign w_run     = (r_state == ST_RUN);
    assign init_done = w_run;

    // Writes and scoreboard sets are only honoured in RUN; entry 0 drops
    // them when it is hardwired to zero.
    assign w_wr_ok  = w_run && !rst && wr_en
                      && !(c_ZERO && (wr_addr == '0));
    assign w_set_ok = w_run && !rst && sb_set_en
                      && !(c_ZERO && (sb_set_addr == '0));

    // Storage array: INIT zeroes one entry per cycle, RUN takes the write port
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next value: write-back clears, issue sets, set applied last
    always_comb begin
        w_sb_next = r_sb;
        if (w_wr_ok) begin
            w_sb_next[wr_addr] = 1'b0;
        end
        if (w_set_ok) begin
            w_sb_next[sb_set_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_fwd;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;
        logic [DATA_W-1:0] r_data;
        logic              r_busy;

        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_zero = c_ZERO && (w_addr == '0);
        assign w_fwd  = c_BYPASS && w_wr_ok && (wr_addr == w_addr);
        assign w_data = w_zero ? '0 : (w_fwd ? wr_data : r_mem[w_addr]);
        // Busy reflects the bit after this edge's set/clear
        assign w_busy = w_zero ? 1'b0 : w_sb_next[w_addr];

        // Read port register: capture on enable in RUN, otherwise hold
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
                r_busy <= 1'b0;
            end else if (w_run && rd_en[gi]) begin
                r_data <= w_data;
                r_busy <= w_busy;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = r_data;
        assign rd_busy[gi]                  = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_core_id_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_id_reg_file_mp
// Description : Scoreboard bench for core_id_reg_file_mp (default parameters).
//               Stimulus pushes expected read results per port; a monitor
//               pops and compares one cycle after each enabled read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_id_reg_file_mp;

`ifdef CORE_REG_FILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic        b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  rd_en = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        sb_set_en = 1'b0;
    logic [4:0]  sb_set_addr = '0;
    logic        init_done;

    int n_cmp = 0;
    int n_mis = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] en_d = '0;

    core_id_reg_file_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read cycle on the selected ports with side inputs already set
    task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic b0, input logic b1);
        exp_t e;
        rd_en   = en;
        rd_addr = {a1, a0};
        if (en[0]) begin e.d = d0; e.b = b0; q0.push_back(e); end
        if (en[1]) begin e.d = d1; e.b = b1; q1.push_back(e); end
        tick();
        rd_en     = '0;
        wr_en     = 1'b0;
        sb_set_en = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk(name, cnt, 32);
    endtask

    // Track which ports read on each edge (reads count only in RUN)
    always @(posedge clk) begin
        en_d <= rst ? 2'b00 : (rd_en & {2{init_done}});
    end

    // Monitor: compare every presented read against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (en_d[0]) begin
            if (q0.size() == 0) begin
                chk("p0_underflow", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("p0_data", rd_data[31:0], e.d);
                chk("p0_busy", {31'd0, rd_busy[0]}, {31'd0, e.b});
            end
        end
        if (en_d[1]) begin
            if (q1.size() == 0) begin
                chk("p1_underflow", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("p1_data", rd_data[63:32], e.d);
                chk("p1_busy", {31'd0, rd_busy[1]}, {31'd0, e.b});
            end
        end
    end

    initial begin
        int cnt;
        repeat (3) tick();
        chk("rst_data", rd_data[31:0] | rd_data[63:32], 32'd0);
        chk("rst_busy", {30'd0, rd_busy}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        // Release reset with writes, sets and reads active; all must be ignored
        rst         = 1'b0;
        rd_en       = 2'b11;
        rd_addr     = {5'd3, 5'd3};
        wr_en       = 1'b1;
        wr_addr     = 5'd3;
        wr_data     = 32'hFFFF_FFFF;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        cnt = 0;
        while (!init_done && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 15) begin
                chk("init_data", rd_data[31:0] | rd_data[63:32], 32'd0);
                chk("init_busy", {30'd0, rd_busy}, 32'd0);
                chk("init_done_low", {31'd0, init_done}, 32'd0);
            end
            if (cnt == 20) begin
                rd_en     = '0;
                wr_en     = 1'b0;
                sb_set_en = 1'b0;
            end
        end
        chk("init_latency", cnt, 32);

        // Every entry cleared and idle
        for (int i = 0; i < 32; i++) begin
            rd(2'b11, 5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b0, 1'b0);
        end

        // Write x5, read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick(); wr_en = 1'b0;
        rd(2'b11, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Entry 0 is hardwired
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        tick(); wr_en = 1'b0;
        rd(2'b01, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        tick(); sb_set_en = 1'b0;
        rd(2'b10, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Same-cycle write/read of x7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        tick(); wr_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22;
        rd(2'b01, 5'd7, 5'd0, c_BYP ? 32'h22 : 32'h11, 32'd0, 1'b0, 1'b0);
        rd(2'b11, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0);

        // Scoreboard on x9
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        tick(); sb_set_en = 1'b0;
        rd(2'b01, 5'd9, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        rd(2'b10, 5'd0, 5'd9, 32'd0, c_BYP ? 32'h99 : 32'd0, 1'b0, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        rd(2'b01, 5'd9, 5'd0, c_BYP ? 32'hAA : 32'h99, 32'd0, 1'b0, 1'b0);
        rd(2'b11, 5'd9, 5'd9, 32'hAA, 32'hAA, 1'b0, 1'b0);

        // Hold while disabled
        sb_set_en = 1'b1; sb_set_addr = 5'd5;
        rd_addr = {5'd5, 5'd5};
        repeat (2) tick();
        sb_set_en = 1'b0;
        chk("hold_data", rd_data[31:0], 32'hAA);
        chk("hold_busy", {30'd0, rd_busy}, 32'd0);

        // Reset in RUN, then again mid-INIT at counter 10
        rst = 1'b1;
        tick();
        chk("rst_run_data", rd_data[31:0] | rd_data[63:32], 32'd0);
        chk("rst_run_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init("reinit_latency");
        rd(2'b11, 5'd5, 5'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        rd(2'b11, 5'd7, 5'd5, 32'd0, 32'd0, 1'b0, 1'b0);

        repeat (2) tick();
        chk("queue_drain", q0.size() + q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
